// File: rtl/issue_scoreboard.sv
// Issue-stage RAW/WAW hazard scoreboard with per-class pending bits and one registered issue stage.
// Latency: 1 cycle from accepted instruction to out_valid; writeback clears bypass combinationally.
// Backpressure: in_ready drops on hazard, on a full inflight budget, on flush, or while the output is held.
module issue_scoreboard #(
  parameter int REG_COUNT    = 32,
  parameter int NUM_WB       = 2,
  parameter int MAX_INFLIGHT = 16,
  parameter int PAYLOAD_W    = 64,
  localparam int IDX_W       = $clog2(REG_COUNT),
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_rs1,
  input  logic [IDX_W-1:0]        in_rs2,
  input  logic [IDX_W-1:0]        in_rd,
  input  logic                    in_uses_rs1,
  input  logic                    in_uses_rs2,
  input  logic                    in_uses_rd,
  input  logic [1:0]              in_rs1_class,
  input  logic [1:0]              in_rs2_class,
  input  logic [1:0]              in_rd_class,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic [IDX_W-1:0]        out_rd,
  output logic [1:0]              out_rd_class,
  output logic                    out_uses_rd,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx,
  input  logic [NUM_WB*2-1:0]     wb_class,
  input  logic                    flush,
  output logic [CNT_W-1:0]        inflight_cnt,
  output logic [31:0]             stall_cycles,
  output logic                    err_spurious_wb
);

  localparam logic [1:0] CLASS_SCALAR = 2'd0;
  localparam logic [1:0] CLASS_BAD    = 2'd3;

  logic [2:0][REG_COUNT-1:0] pending_q, pending_d, clr_mask, eff_pending, set_mask;
  logic [CNT_W-1:0]          inflight_q, inflight_d, dec_cnt, cnt_after;
  logic [31:0]               stall_q, stall_d;
  logic                      err_q, err_d, spur;
  logic                      out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0]      out_payload_q, out_payload_d;
  logic [IDX_W-1:0]          out_rd_q, out_rd_d;
  logic [1:0]                out_rd_class_q, out_rd_class_d;
  logic                      out_uses_rd_q, out_uses_rd_d;
  logic                      raw, waw, full, hazard, out_free, fire, set_ok;

  // Class 3 has no register file, so nothing in it is ever pending.
  function automatic logic pend_at(input logic [2:0][REG_COUNT-1:0] p,
                                   input logic [1:0] c, input logic [IDX_W-1:0] i);
    return (c == CLASS_BAD) ? 1'b0 : p[c][i];
  endfunction

  // Writeback decode: clear mask, distinct-hit decrement count, spurious detection (x0 is ignored).
  always_comb begin
    clr_mask = '0;
    dec_cnt  = '0;
    spur     = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      logic [1:0]       c;
      logic [IDX_W-1:0] i;
      logic             live, dup;
      c    = wb_class[p*2 +: 2];
      i    = wb_idx[p*IDX_W +: IDX_W];
      live = wb_valid[p] && (c != CLASS_BAD) && !(c == CLASS_SCALAR && i == '0);
      dup  = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (wb_valid[q] && wb_class[q*2 +: 2] == c && wb_idx[q*IDX_W +: IDX_W] == i)
          dup = 1'b1;
      end
      if (live) begin
        clr_mask[c][i] = 1'b1;
        if (pending_q[c][i]) begin
          if (!dup) dec_cnt = dec_cnt + CNT_W'(1);
        end else begin
          spur = 1'b1;
        end
      end
    end
  end

  // Hazard evaluation against pending state with same-cycle writebacks already removed.
  always_comb begin
    eff_pending = pending_q & ~clr_mask;
    cnt_after   = inflight_q - dec_cnt;
    raw      = (in_uses_rs1 && pend_at(eff_pending, in_rs1_class, in_rs1)) ||
               (in_uses_rs2 && pend_at(eff_pending, in_rs2_class, in_rs2));
    waw      = in_uses_rd && pend_at(eff_pending, in_rd_class, in_rd);
    full     = in_uses_rd && (cnt_after == CNT_W'(MAX_INFLIGHT));
    hazard   = raw || waw || full;
    out_free = !out_valid_q || out_ready;
    in_ready = !hazard && out_free && !flush;
    fire     = in_valid && in_ready;
    set_ok   = fire && in_uses_rd && (in_rd_class != CLASS_BAD) &&
               !(in_rd_class == CLASS_SCALAR && in_rd == '0);
    set_mask = '0;
    if (set_ok) set_mask[in_rd_class][in_rd] = 1'b1;
  end

  // Next-state for pending bits, counters, error flag and the issue register.
  always_comb begin
    pending_d      = flush ? '0 : (eff_pending | set_mask);
    inflight_d     = flush ? '0 : (cnt_after + (set_ok ? CNT_W'(1) : CNT_W'(0)));
    stall_d        = (in_valid && hazard && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
    err_d          = err_q || (spur && !flush);
    out_valid_d    = out_valid_q;
    out_payload_d  = out_payload_q;
    out_rd_d       = out_rd_q;
    out_rd_class_d = out_rd_class_q;
    out_uses_rd_d  = out_uses_rd_q;
    if (fire) begin
      out_valid_d    = 1'b1;
      out_payload_d  = in_payload;
      out_rd_d       = in_rd;
      out_rd_class_d = in_rd_class;
      out_uses_rd_d  = in_uses_rd;
    end else if (out_ready || flush) begin
      out_valid_d    = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      inflight_q     <= '0;
      stall_q        <= '0;
      err_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_payload_q  <= '0;
      out_rd_q       <= '0;
      out_rd_class_q <= '0;
      out_uses_rd_q  <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      inflight_q     <= inflight_d;
      stall_q        <= stall_d;
      err_q          <= err_d;
      out_valid_q    <= out_valid_d;
      out_payload_q  <= out_payload_d;
      out_rd_q       <= out_rd_d;
      out_rd_class_q <= out_rd_class_d;
      out_uses_rd_q  <= out_uses_rd_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_payload     = out_payload_q;
  assign out_rd          = out_rd_q;
  assign out_rd_class    = out_rd_class_q;
  assign out_uses_rd     = out_uses_rd_q;
  assign inflight_cnt    = inflight_q;
  assign stall_cycles    = stall_q;
  assign err_spurious_wb = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, class isolation, x0, capacity, writeback and flush.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
// out_ready is held high except where output hold is exercised.
module tb_issue_scoreboard;
  localparam logic [1:0] SC = 2'd0, FP = 2'd1, VC = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_uses_rd;
  logic [1:0]  in_rs1_class, in_rs2_class, in_rd_class;
  logic [63:0] in_payload;
  logic        out_valid, out_ready;
  logic [63:0] out_payload;
  logic [4:0]  out_rd;
  logic [1:0]  out_rd_class;
  logic        out_uses_rd;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_idx;
  logic [3:0]  wb_class;
  logic        flush;
  logic [4:0]  inflight_cnt;
  logic [31:0] stall_cycles;
  logic        err_spurious_wb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_uses_rd(in_uses_rd),
    .in_rs1_class(in_rs1_class), .in_rs2_class(in_rs2_class), .in_rd_class(in_rd_class),
    .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rd(out_rd), .out_rd_class(out_rd_class), .out_uses_rd(out_uses_rd),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_class(wb_class),
    .flush(flush), .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles),
    .err_spurious_wb(err_spurious_wb)
  );

  task automatic set_instr(input logic [4:0] rs1, input logic u1, input logic [1:0] c1,
                           input logic [4:0] rs2, input logic u2, input logic [1:0] c2,
                           input logic [4:0] rd,  input logic ud, input logic [1:0] cd,
                           input logic [63:0] pl);
    in_valid = 1'b1;
    in_rs1 = rs1; in_uses_rs1 = u1; in_rs1_class = c1;
    in_rs2 = rs2; in_uses_rs2 = u2; in_rs2_class = c2;
    in_rd  = rd;  in_uses_rd  = ud; in_rd_class  = cd;
    in_payload = pl;
  endtask

  task automatic clear_in();
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 64'h0);
    in_valid = 1'b0;
  endtask

  task automatic set_wb(input logic [1:0] v, input logic [4:0] i0, input logic [1:0] c0,
                        input logic [4:0] i1, input logic [1:0] c1);
    wb_valid = v; wb_idx = {i1, i0}; wb_class = {c1, c0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd5, 1'b1, SC, 64'hADD5);
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h exp 0", out_valid); end
    checks++; if (out_payload !== 64'h0) begin errors++; $display("FAIL reset_out_payload: got %0h exp 0", out_payload); end
    checks++; if (out_rd !== 5'd0 || out_rd_class !== 2'd0 || out_uses_rd !== 1'b0) begin errors++; $display("FAIL reset_out_rd: got %0h/%0h/%0h exp 0/0/0", out_rd, out_rd_class, out_uses_rd); end
    checks++; if (inflight_cnt !== 5'd0) begin errors++; $display("FAIL reset_inflight: got %0d exp 0", inflight_cnt); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d exp 0", stall_cycles); end
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h exp 0", err_spurious_wb); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %0h exp 1", in_ready); end
    step();
    clear_in();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %0h exp 1", out_valid); end
    checks++; if (out_rd !== 5'd5 || out_payload !== 64'hADD5) begin errors++; $display("FAIL first_out: got rd %0d pl %0h exp rd 5 pl add5", out_rd, out_payload); end
    checks++; if (inflight_cnt !== 5'd1) begin errors++; $display("FAIL first_inflight: got %0d exp 1", inflight_cnt); end
  endtask

  task automatic test_raw();
    set_instr(5'd5, 1'b1, SC, 5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 64'h5A5A);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_block[%0d]: got %0h exp 0", k, in_ready); end
      step();
    end
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL raw_stall: got %0d exp 3", stall_cycles); end
    set_wb(2'b01, 5'd5, SC, 5'd0, SC);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready: got %0h exp 1", in_ready); end
    step();
    set_wb(2'b00, 5'd0, SC, 5'd0, SC);
    clear_in();
    checks++; if (inflight_cnt !== 5'd0) begin errors++; $display("FAIL raw_inflight: got %0d exp 0", inflight_cnt); end
    checks++; if (out_valid !== 1'b1 || out_payload !== 64'h5A5A) begin errors++; $display("FAIL raw_issue: got v %0h pl %0h exp v 1 pl 5a5a", out_valid, out_payload); end
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL raw_stall_after: got %0d exp 3", stall_cycles); end
  endtask

  task automatic test_class_isolation();
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd5, 1'b1, FP, 64'hF5);
    step();
    checks++; if (inflight_cnt !== 5'd1 || out_rd_class !== FP) begin errors++; $display("FAIL class_f5_issue: got cnt %0d cls %0d exp 1/1", inflight_cnt, out_rd_class); end
    set_instr(5'd5, 1'b1, SC, 5'd5, 1'b1, VC, 5'd0, 1'b0, SC, 64'hC1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL class_read_ready: got %0h exp 1", in_ready); end
    step();
    checks++; if (out_payload !== 64'hC1) begin errors++; $display("FAIL class_read_issue: got %0h exp c1", out_payload); end
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd5, 1'b1, FP, 64'hF55);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL class_waw_block: got %0h exp 0", in_ready); end
    step();
    checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL class_waw_stall: got %0d exp 4", stall_cycles); end
    clear_in();
    set_wb(2'b01, 5'd5, FP, 5'd0, SC);
    step();
    set_wb(2'b00, 5'd0, SC, 5'd0, SC);
    checks++; if (inflight_cnt !== 5'd0 || err_spurious_wb !== 1'b0) begin errors++; $display("FAIL class_wb_f5: got cnt %0d err %0h exp 0/0", inflight_cnt, err_spurious_wb); end
  endtask

  task automatic test_x0();
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd0, 1'b1, SC, 64'h0A0);
    step();
    checks++; if (inflight_cnt !== 5'd0 || out_uses_rd !== 1'b1 || out_payload !== 64'h0A0) begin errors++; $display("FAIL x0_write: got cnt %0d urd %0h pl %0h exp 0/1/a0", inflight_cnt, out_uses_rd, out_payload); end
    set_instr(5'd0, 1'b1, SC, 5'd0, 1'b1, SC, 5'd0, 1'b0, SC, 64'h10);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_read_ready: got %0h exp 1", in_ready); end
    step();
    clear_in();
    checks++; if (out_payload !== 64'h10 || stall_cycles !== 32'd4) begin errors++; $display("FAIL x0_read_issue: got pl %0h stall %0d exp 10/4", out_payload, stall_cycles); end
  endtask

  task automatic test_capacity();
    for (int i = 0; i < 16; i++) begin
      set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'(i), 1'b1, VC, 64'h100 + 64'(i));
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cap_fill_ready[%0d]: got %0h exp 1", i, in_ready); end
      step();
    end
    checks++; if (inflight_cnt !== 5'd16 || out_payload !== 64'h10F) begin errors++; $display("FAIL cap_full_cnt: got %0d pl %0h exp 16/10f", inflight_cnt, out_payload); end
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd16, 1'b1, VC, 64'h117);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cap_17th_block: got %0h exp 0", in_ready); end
    step();
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL cap_stall: got %0d exp 5", stall_cycles); end
    set_instr(5'd1, 1'b1, SC, 5'd2, 1'b1, SC, 5'd0, 1'b0, SC, 64'h57);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cap_store_ready: got %0h exp 1", in_ready); end
    step();
    checks++; if (out_uses_rd !== 1'b0 || out_payload !== 64'h57) begin errors++; $display("FAIL cap_store_issue: got urd %0h pl %0h exp 0/57", out_uses_rd, out_payload); end
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd16, 1'b1, VC, 64'h117);
    set_wb(2'b10, 5'd0, SC, 5'd3, VC);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cap_wb_ready: got %0h exp 1", in_ready); end
    step();
    clear_in();
    checks++; if (inflight_cnt !== 5'd16 || out_rd !== 5'd16) begin errors++; $display("FAIL cap_wb_issue: got cnt %0d rd %0d exp 16/16", inflight_cnt, out_rd); end
    // both ports hit v0: one distinct bit, one decrement
    set_wb(2'b11, 5'd0, VC, 5'd0, VC);
    step();
    set_wb(2'b00, 5'd0, SC, 5'd0, SC);
    checks++; if (inflight_cnt !== 5'd15 || err_spurious_wb !== 1'b0) begin errors++; $display("FAIL cap_dup_wb: got cnt %0d err %0h exp 15/0", inflight_cnt, err_spurious_wb); end
  endtask

  task automatic test_flush_ignores_wb();
    flush = 1'b1;
    set_wb(2'b01, 5'd20, FP, 5'd0, SC);
    set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 64'hEE);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush1_ready: got %0h exp 0", in_ready); end
    step();
    flush = 1'b0;
    set_wb(2'b00, 5'd0, SC, 5'd0, SC);
    clear_in();
    checks++; if (inflight_cnt !== 5'd0 || out_valid !== 1'b0 || err_spurious_wb !== 1'b0) begin errors++; $display("FAIL flush1_state: got cnt %0d v %0h err %0h exp 0/0/0", inflight_cnt, out_valid, err_spurious_wb); end
    set_instr(5'd4, 1'b1, VC, 5'd0, 1'b0, SC, 5'd4, 1'b1, VC, 64'h44);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush1_cleared: got %0h exp 1", in_ready); end
    step();
    clear_in();
    set_wb(2'b01, 5'd4, VC, 5'd0, SC);
    step();
    set_wb(2'b00, 5'd0, SC, 5'd0, SC);
    checks++; if (inflight_cnt !== 5'd0) begin errors++; $display("FAIL flush1_v4_wb: got %0d exp 0", inflight_cnt); end
  endtask

  task automatic test_spurious_wb();
    set_wb(2'b01, 5'd9, FP, 5'd0, SC);
    step();
    set_wb(2'b00, 5'd0, SC, 5'd0, SC);
    checks++; if (err_spurious_wb !== 1'b1 || inflight_cnt !== 5'd0) begin errors++; $display("FAIL spurious_f9: got err %0h cnt %0d exp 1/0", err_spurious_wb, inflight_cnt); end
  endtask

  task automatic test_hold_and_flush();
    for (int i = 1; i <= 4; i++) begin
      set_instr(5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 5'(i), 1'b1, FP, 64'h200 + 64'(i));
      step();
    end
    checks++; if (inflight_cnt !== 5'd4 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_setup: got cnt %0d v %0h exp 4/1", inflight_cnt, out_valid); end
    out_ready = 1'b0;
    set_instr(5'd7, 1'b1, SC, 5'd0, 1'b0, SC, 5'd0, 1'b0, SC, 64'h77);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %0h exp 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_payload !== 64'h204 || out_rd !== 5'd4) begin errors++; $display("FAIL hold_stable: got v %0h pl %0h rd %0d exp 1/204/4", out_valid, out_payload, out_rd); end
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL hold_no_stall_count: got %0d exp 5", stall_cycles); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush2_ready: got %0h exp 0", in_ready); end
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    clear_in();
    checks++; if (inflight_cnt !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush2_state: got cnt %0d v %0h exp 0/0", inflight_cnt, out_valid); end
    checks++; if (err_spurious_wb !== 1'b1 || stall_cycles !== 32'd5) begin errors++; $display("FAIL flush2_retained: got err %0h stall %0d exp 1/5", err_spurious_wb, stall_cycles); end
  endtask

  initial begin
    out_ready = 1'b1;
    flush = 1'b0;
    set_wb(2'b00, 5'd0, SC, 5'd0, SC);
    clear_in();
    test_reset();
    test_raw();
    test_class_isolation();
    test_x0();
    test_capacity();
    test_flush_ignores_wb();
    test_spurious_wb();
    test_hold_and_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Issue-stage hazard controller placed between the instruction decoder and the execute/memory pipes. It takes decoded operand fields (register indices, use flags, register classes) and tracks pending destination writes per class (scalar, FP, vector). It blocks RAW and WAW hazards and hands hazard-free instructions to execute through one registered output stage. It also maintains a stall counter and a spurious-writeback error flag.

Parameters:
REG_COUNT, 32, registers per class; index width is $clog2(REG_COUNT)
NUM_WB, 2, number of independent writeback/clear ports
MAX_INFLIGHT, 16, maximum outstanding rd-writing instructions, summed over all classes
PAYLOAD_W, 64, width of the opaque instruction payload forwarded to execute

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  scoreboard accepts the instruction this cycle
in_rs1 / in_rs2 / in_rd  in  5 each  register indices
in_uses_rs1 / in_uses_rs2 / in_uses_rd  in  1 each  operand use flags from decode
in_rs1_class / in_rs2_class / in_rd_class  in  2 each  isa_pkg class encoding: CLASS_SCALAR, CLASS_FP, CLASS_VEC
in_payload  in  PAYLOAD_W  opaque decoded fields, forwarded unchanged
out_valid  out  1  registered issue valid
out_ready  in  1  execute accepts
out_payload  out  PAYLOAD_W  registered payload
out_rd / out_rd_class / out_uses_rd  out  5/2/1  registered destination info
wb_valid  in  NUM_WB  per-port writeback/clear strobe
wb_idx  in  NUM_WB*5  per-port register index
wb_class  in  NUM_WB*2  per-port register class
flush  in  1  synchronous clear of all pending state and the output register
inflight_cnt  out  $clog2(MAX_INFLIGHT+1)  outstanding rd writers
stall_cycles  out  32  saturating count of cycles with in_valid=1 and a hazard
err_spurious_wb  out  1  sticky: a writeback hit a non-pending register

Behaviour:
- Reset (async, rst_n=0): all pending bits=0, out_valid=0, out_payload/out_rd/out_rd_class/out_uses_rd=0, inflight_cnt=0, stall_cycles=0, err_spurious_wb=0.
- State: pending[class][idx], 3x REG_COUNT bits. Scalar register 0 is never set pending. Writes to it are ignored, and reads of it never hazard.
- Effective pending for this cycle = registered pending AND NOT (same-cycle wb clear match). Writeback bypass is combinational, so an instruction may issue in the same cycle as the writeback that resolves its hazard.
- raw = (uses_rs1 and eff_pending[rs1_class][rs1]) or (uses_rs2 and eff_pending[rs2_class][rs2]).
- waw = uses_rd and eff_pending[rd_class][rd].
- full = uses_rd and inflight_cnt == MAX_INFLIGHT, using the count after same-cycle decrements.
- hazard = raw or waw or full.
- out_free = !out_valid or out_ready.
- in_ready = !hazard and out_free and !flush.
- fire = in_valid and in_ready.
- On fire: load the output register with the instruction and set out_valid=1. If uses_rd and rd is not scalar x0, set pending[rd_class][rd] and increment inflight_cnt. Latency from fire to out_valid is 1 cycle.
- If out_ready=1 and there is no fire, clear out_valid. While out_valid=1 and out_ready=0, all output fields hold stable.
- Writeback: each wb_valid port clears its pending bit at the clock edge and decrements inflight_cnt by one if the bit was set. Multiple ports in one cycle decrement by the number of distinct set bits cleared. Duplicate ports hitting the same register count once.
- A wb to a bit that is not set (registered value) sets err_spurious_wb. The counter is not decremented. The flag clears only on reset.
- Simultaneous set and clear of the same bit cannot occur, because WAW blocks it. Same-cycle set of register A and clear of register B are both applied.
- stall_cycles: increments when in_valid and hazard; saturates at 0xFFFFFFFF. Stalls caused only by out_free=0 are not counted.
- flush=1: at the next edge, clear all pending bits, inflight_cnt=0 and out_valid=0. in_ready=0 during the flush cycle. Any wb in that cycle is ignored and does not set the error. stall_cycles and err_spurious_wb are retained.

Test Plan:
- Reset with in_valid=1: outputs at reset values; after release, ADD rd=x5 (scalar) fires; next cycle out_valid=1, out_rd=5, inflight_cnt=1.
- RAW: after x5 is pending, instruction with rs1=x5 scalar gets in_ready=0 for 3 cycles and stall_cycles=3. wb_valid[0] with idx 5 and CLASS_SCALAR causes same-cycle fire; pending cleared and inflight_cnt=0.
- Class isolation: f5 (CLASS_FP) pending; instruction reads scalar x5 and vector v5 -> fires immediately. Instruction writing f5 -> blocked by WAW.
- x0: rd=x0 issues with inflight_cnt unchanged; a subsequent reader of x0 never stalls.
- Capacity: 16 writers to distinct vector registers with out_ready=1 give inflight_cnt=16. A 17th writer stalls, while a non-rd instruction (store) still issues. One wb lets the 17th issue in that same cycle.
- Error/flush: wb to non-pending f9 sets err_spurious_wb=1. Flush with 4 pending and out_valid=1 gives inflight_cnt=0 and out_valid=0 next cycle; err_spurious_wb stays 1.
